// File: rtl/expansion_shiftreg_target.sv
// Responder end of a 74HC165/74HC595-style expansion chain: receives a word MSB-first,
// publishes it on each load strobe and returns par_in (captured at that strobe) next frame.
module expansion_shiftreg_target #(
  parameter int               WIDTH      = 8,
  parameter int               TIMEOUT    = 1000000,
  parameter logic [WIDTH-1:0] SAFE_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SHIFT_CLK,
  input  logic             SHIFT_LOAD,
  input  logic             SHIFT_OUT,
  output logic             SHIFT_IN,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] par_out,
  output logic             frame_strobe,
  output logic             frame_error,
  output logic             link_ok
);

  localparam int               WD_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0]  WD_MAX    = WD_W'(TIMEOUT);
  localparam logic [7:0]       WIDTH_CNT = 8'(WIDTH);
  localparam logic [7:0]       CNT_MAX   = 8'd255;

  // Stage [0] and [1] form the synchroniser, stage [2] is the edge-detect history.
  logic [2:0]       sclk_sync_q, sclk_sync_d;
  logic [2:0]       sload_sync_q, sload_sync_d;
  logic [1:0]       sout_sync_q, sout_sync_d;
  logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [7:0]       bit_cnt_q, bit_cnt_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [WIDTH-1:0] par_out_q, par_out_d;
  logic             shift_in_q, shift_in_d;
  logic             frame_strobe_q, frame_strobe_d;
  logic             frame_error_q, frame_error_d;
  logic             link_ok_q, link_ok_d;

  logic clk_rise, load_rise, load_high, shift_en, frame_ok, wd_expire;

  always_comb begin
    sclk_sync_d  = {sclk_sync_q[1:0], SHIFT_CLK};
    sload_sync_d = {sload_sync_q[1:0], SHIFT_LOAD};
    sout_sync_d  = {sout_sync_q[0], SHIFT_OUT};

    clk_rise  = sclk_sync_q[1] & ~sclk_sync_q[2];
    load_rise = sload_sync_q[1] & ~sload_sync_q[2];
    load_high = sload_sync_q[1];
    // A load edge wins over a coincident clock edge; clocks during the load pulse are ignored.
    shift_en  = clk_rise & load_high & ~load_rise;
    frame_ok  = load_rise & (bit_cnt_q == WIDTH_CNT);
  end

  always_comb begin
    rx_shift_d     = rx_shift_q;
    tx_shift_d     = tx_shift_q;
    bit_cnt_d      = bit_cnt_q;
    frame_error_d  = frame_error_q;
    frame_strobe_d = frame_ok;

    if (load_rise) begin
      tx_shift_d = par_in;
      bit_cnt_d  = '0;
      if (!frame_ok) frame_error_d = 1'b1;
    end else if (shift_en) begin
      rx_shift_d = {rx_shift_q[WIDTH-2:0], sout_sync_q[1]};
      tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
      if (bit_cnt_q != CNT_MAX) bit_cnt_d = bit_cnt_q + 8'd1;
    end

    shift_in_d = tx_shift_d[WIDTH-1];
  end

  // Watchdog: saturating cycle counter cleared only by a valid frame.
  always_comb begin
    wd_d = wd_q;
    if (frame_ok) begin
      wd_d = '0;
    end else if ((TIMEOUT > 0) && (wd_q != WD_MAX)) begin
      wd_d = wd_q + 1'b1;
    end
    wd_expire = (TIMEOUT > 0) && !frame_ok && (wd_d == WD_MAX);

    par_out_d = par_out_q;
    link_ok_d = link_ok_q;
    if (frame_ok) begin
      par_out_d = rx_shift_q;
      link_ok_d = 1'b1;
    end else if (wd_expire) begin
      par_out_d = SAFE_VALUE;
      link_ok_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q    <= '0;
      // Load idles high, so its history resets high to avoid a phantom load edge.
      sload_sync_q   <= '1;
      sout_sync_q    <= '0;
      rx_shift_q     <= '0;
      tx_shift_q     <= '0;
      bit_cnt_q      <= '0;
      wd_q           <= '0;
      par_out_q      <= SAFE_VALUE;
      shift_in_q     <= 1'b0;
      frame_strobe_q <= 1'b0;
      frame_error_q  <= 1'b0;
      link_ok_q      <= 1'b0;
    end else begin
      sclk_sync_q    <= sclk_sync_d;
      sload_sync_q   <= sload_sync_d;
      sout_sync_q    <= sout_sync_d;
      rx_shift_q     <= rx_shift_d;
      tx_shift_q     <= tx_shift_d;
      bit_cnt_q      <= bit_cnt_d;
      wd_q           <= wd_d;
      par_out_q      <= par_out_d;
      shift_in_q     <= shift_in_d;
      frame_strobe_q <= frame_strobe_d;
      frame_error_q  <= frame_error_d;
      link_ok_q      <= link_ok_d;
    end
  end

  assign SHIFT_IN     = shift_in_q;
  assign par_out      = par_out_q;
  assign frame_strobe = frame_strobe_q;
  assign frame_error  = frame_error_q;
  assign link_ok      = link_ok_q;

endmodule

// File: tb/tb_expansion_shiftreg_target.sv
// Directed bench for expansion_shiftreg_target: a pin-level master model drives frames
// into a default instance and a TIMEOUT=100 instance sharing the same link.
module tb_expansion_shiftreg_target;

  logic       clk = 1'b0;
  logic       rst;
  logic       shift_clk, shift_load, shift_out;
  logic [7:0] par_in;

  logic       shift_in,  shift_in_wd;
  logic [7:0] par_out,   par_out_wd;
  logic       strobe,    strobe_wd;
  logic       error,     error_wd;
  logic       link,      link_wd;

  int tests_run = 0;
  int tests_failed = 0;
  int strobe_cnt = 0;

  always #5 clk = ~clk;

  expansion_shiftreg_target dut (
    .clk(clk), .rst(rst),
    .SHIFT_CLK(shift_clk), .SHIFT_LOAD(shift_load), .SHIFT_OUT(shift_out),
    .SHIFT_IN(shift_in), .par_in(par_in), .par_out(par_out),
    .frame_strobe(strobe), .frame_error(error), .link_ok(link)
  );

  expansion_shiftreg_target #(.WIDTH(8), .TIMEOUT(100), .SAFE_VALUE(8'hE7)) dut_wd (
    .clk(clk), .rst(rst),
    .SHIFT_CLK(shift_clk), .SHIFT_LOAD(shift_load), .SHIFT_OUT(shift_out),
    .SHIFT_IN(shift_in_wd), .par_in(par_in), .par_out(par_out_wd),
    .frame_strobe(strobe_wd), .frame_error(error_wd), .link_ok(link_wd)
  );

  always @(posedge clk) if (strobe === 1'b1) strobe_cnt++;

  // ---------------- driver tasks ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Shifts bits first..last of data (MSB-first index 0 = bit 7), 8-cycle phases;
  // samples SHIFT_IN just before each clock rise.
  task automatic shift_bits(input logic [7:0] data, input int first, input int last,
                            output logic [7:0] rd);
    rd = '0;
    for (int i = first; i <= last; i++) begin
      shift_clk = 1'b0;
      shift_out = data[7-i];
      wait_clks(8);
      rd[7-i] = shift_in;
      shift_clk = 1'b1;
      wait_clks(8);
    end
    shift_clk = 1'b0;
    wait_clks(8);
  endtask

  task automatic load_pulse();
    shift_load = 1'b0;
    wait_clks(8);
    shift_load = 1'b1;
    wait_clks(8);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    wait_clks(5);
    rst = 1'b0;
    wait_clks(2);
    tests_run++; if (par_out !== 8'h00) begin tests_failed++; $display("FAIL reset_par_out got %h exp 00", par_out); end
    tests_run++; if (shift_in !== 1'b0) begin tests_failed++; $display("FAIL reset_shift_in got %b exp 0", shift_in); end
    tests_run++; if (strobe !== 1'b0) begin tests_failed++; $display("FAIL reset_strobe got %b exp 0", strobe); end
    tests_run++; if (error !== 1'b0) begin tests_failed++; $display("FAIL reset_error got %b exp 0", error); end
    tests_run++; if (link !== 1'b0) begin tests_failed++; $display("FAIL reset_link got %b exp 0", link); end
    tests_run++; if (par_out_wd !== 8'hE7) begin tests_failed++; $display("FAIL reset_safe_value got %h exp e7", par_out_wd); end
  endtask

  task automatic test_basic();
    logic [7:0] rd;
    int s0;
    s0 = strobe_cnt;
    par_in = 8'h3C;
    shift_bits(8'hA5, 0, 7, rd);
    tests_run++; if (rd !== 8'h00) begin tests_failed++; $display("FAIL basic_first_return got %h exp 00", rd); end
    load_pulse();
    tests_run++; if (par_out !== 8'hA5) begin tests_failed++; $display("FAIL basic_par_out got %h exp a5", par_out); end
    tests_run++; if (strobe_cnt - s0 !== 1) begin tests_failed++; $display("FAIL basic_strobe_count got %0d exp 1", strobe_cnt - s0); end
    tests_run++; if (link !== 1'b1) begin tests_failed++; $display("FAIL basic_link got %b exp 1", link); end
    tests_run++; if (error !== 1'b0) begin tests_failed++; $display("FAIL basic_error got %b exp 0", error); end
    tests_run++; if (shift_in !== 1'b0) begin tests_failed++; $display("FAIL basic_shift_in_msb got %b exp 0", shift_in); end
    par_in = 8'h11;
    shift_bits(8'h00, 0, 7, rd);
    tests_run++; if (rd !== 8'h3C) begin tests_failed++; $display("FAIL basic_return got %h exp 3c", rd); end
    load_pulse();
    tests_run++; if (par_out !== 8'h00) begin tests_failed++; $display("FAIL basic_par_out2 got %h exp 00", par_out); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words[3] = '{8'h01, 8'h80, 8'hFF};
    logic [7:0] pins[3]  = '{8'h22, 8'h33, 8'h44};
    logic [7:0] prev_word, prev_pin, rd;
    int s0;
    prev_word = 8'h00;
    prev_pin  = 8'h11;
    for (int k = 0; k < 3; k++) begin
      s0 = strobe_cnt;
      par_in = pins[k];
      shift_bits(words[k], 0, 7, rd);
      tests_run++; if (par_out !== prev_word) begin tests_failed++; $display("FAIL b2b_hold[%0d] got %h exp %h", k, par_out, prev_word); end
      tests_run++; if (rd !== prev_pin) begin tests_failed++; $display("FAIL b2b_return[%0d] got %h exp %h", k, rd, prev_pin); end
      load_pulse();
      tests_run++; if (par_out !== words[k]) begin tests_failed++; $display("FAIL b2b_par_out[%0d] got %h exp %h", k, par_out, words[k]); end
      tests_run++; if (strobe_cnt - s0 !== 1) begin tests_failed++; $display("FAIL b2b_strobe[%0d] got %0d exp 1", k, strobe_cnt - s0); end
      prev_word = words[k];
      prev_pin  = pins[k];
    end
  endtask

  task automatic test_coincide();
    logic [7:0] rd;
    int s0;
    s0 = strobe_cnt;
    par_in = 8'hC6;
    shift_bits(8'h5A, 0, 7, rd);
    tests_run++; if (rd !== 8'h44) begin tests_failed++; $display("FAIL coincide_return got %h exp 44", rd); end
    shift_load = 1'b0;
    wait_clks(8);
    shift_clk  = 1'b1;
    shift_load = 1'b1;
    wait_clks(8);
    tests_run++; if (par_out !== 8'h5A) begin tests_failed++; $display("FAIL coincide_par_out got %h exp 5a", par_out); end
    tests_run++; if (shift_in !== 1'b1) begin tests_failed++; $display("FAIL coincide_shift_in got %b exp 1", shift_in); end
    tests_run++; if (strobe_cnt - s0 !== 1) begin tests_failed++; $display("FAIL coincide_strobe got %0d exp 1", strobe_cnt - s0); end
    par_in = 8'h00;
    shift_bits(8'h3E, 0, 7, rd);
    tests_run++; if (rd !== 8'hC6) begin tests_failed++; $display("FAIL coincide_next_return got %h exp c6", rd); end
    load_pulse();
    tests_run++; if (error !== 1'b0) begin tests_failed++; $display("FAIL coincide_no_error got %b exp 0", error); end
    tests_run++; if (par_out !== 8'h3E) begin tests_failed++; $display("FAIL coincide_next_par_out got %h exp 3e", par_out); end
  endtask

  task automatic test_frame_error();
    logic [7:0] rd;
    int s0;
    shift_bits(8'h55, 0, 7, rd);
    load_pulse();
    tests_run++; if (par_out !== 8'h55) begin tests_failed++; $display("FAIL err_setup got %h exp 55", par_out); end
    s0 = strobe_cnt;
    shift_bits(8'hF0, 0, 6, rd);
    load_pulse();
    tests_run++; if (par_out !== 8'h55) begin tests_failed++; $display("FAIL err_par_out_kept got %h exp 55", par_out); end
    tests_run++; if (error !== 1'b1) begin tests_failed++; $display("FAIL err_flag got %b exp 1", error); end
    tests_run++; if (strobe_cnt - s0 !== 0) begin tests_failed++; $display("FAIL err_no_strobe got %0d exp 0", strobe_cnt - s0); end
    shift_bits(8'h12, 0, 7, rd);
    load_pulse();
    tests_run++; if (par_out !== 8'h12) begin tests_failed++; $display("FAIL err_recover got %h exp 12", par_out); end
    tests_run++; if (error !== 1'b1) begin tests_failed++; $display("FAIL err_sticky got %b exp 1", error); end
  endtask

  task automatic test_timeout();
    logic [7:0] rd;
    int n;
    bit seen;
    shift_bits(8'h42, 0, 7, rd);
    shift_load = 1'b0;
    wait_clks(8);
    shift_load = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (strobe_wd === 1'b1) seen = 1;
    end
    tests_run++; if (!seen) begin tests_failed++; $display("FAIL wd_strobe got none exp pulse within 20 cycles"); end
    tests_run++; if (par_out_wd !== 8'h42) begin tests_failed++; $display("FAIL wd_par_out got %h exp 42", par_out_wd); end
    tests_run++; if (link_wd !== 1'b1) begin tests_failed++; $display("FAIL wd_link_up got %b exp 1", link_wd); end
    n = 0;
    while (link_wd === 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    tests_run++; if (n !== 100) begin tests_failed++; $display("FAIL wd_fall_cycle got %0d exp 100", n); end
    tests_run++; if (par_out_wd !== 8'hE7) begin tests_failed++; $display("FAIL wd_safe got %h exp e7", par_out_wd); end
    wait_clks(50);
    tests_run++; if (link !== 1'b1) begin tests_failed++; $display("FAIL wd_default_link got %b exp 1", link); end
    shift_bits(8'h42, 0, 7, rd);
    load_pulse();
    tests_run++; if (par_out_wd !== 8'h42) begin tests_failed++; $display("FAIL wd_restore got %h exp 42", par_out_wd); end
    tests_run++; if (link_wd !== 1'b1) begin tests_failed++; $display("FAIL wd_relink got %b exp 1", link_wd); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rd;
    int s0;
    shift_bits(8'h99, 0, 3, rd);
    rst = 1'b1;
    wait_clks(2);
    rst = 1'b0;
    wait_clks(2);
    tests_run++; if (par_out !== 8'h00) begin tests_failed++; $display("FAIL mid_par_out got %h exp 00", par_out); end
    tests_run++; if (error !== 1'b0) begin tests_failed++; $display("FAIL mid_error_clr got %b exp 0", error); end
    tests_run++; if (link !== 1'b0) begin tests_failed++; $display("FAIL mid_link got %b exp 0", link); end
    s0 = strobe_cnt;
    shift_bits(8'h99, 4, 7, rd);
    load_pulse();
    tests_run++; if (error !== 1'b1) begin tests_failed++; $display("FAIL mid_short_flag got %b exp 1", error); end
    tests_run++; if (par_out !== 8'h00) begin tests_failed++; $display("FAIL mid_short_par_out got %h exp 00", par_out); end
    tests_run++; if (strobe_cnt - s0 !== 0) begin tests_failed++; $display("FAIL mid_short_strobe got %0d exp 0", strobe_cnt - s0); end
    shift_bits(8'h99, 0, 7, rd);
    load_pulse();
    tests_run++; if (par_out !== 8'h99) begin tests_failed++; $display("FAIL mid_full_par_out got %h exp 99", par_out); end
    tests_run++; if (strobe_cnt - s0 !== 1) begin tests_failed++; $display("FAIL mid_full_strobe got %0d exp 1", strobe_cnt - s0); end
  endtask

  initial begin
    rst        = 1'b1;
    shift_clk  = 1'b0;
    shift_load = 1'b1;
    shift_out  = 1'b0;
    par_in     = 8'h00;
    test_reset();
    test_basic();
    test_back_to_back();
    test_coincide();
    test_frame_error();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
